// File: rtl/ring_ctrl_fsm_if.sv
// Handshake bundle between the ring controller and the rx decoder, tx serializer and node core.
// master = controller side, slave = surrounding datapath/core side.
interface ring_ctrl_fsm_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              rx_has_data;
    logic [2:0]        rx_type;
    logic [ADDR_W-1:0] rx_dest;
    logic              bad_decode;
    logic              tx_ready;
    logic              Packet_From_Node_Valid;
    logic              Packet_To_Node_Valid;
    logic              Core_Load_Ack;
    logic              buffer_select;
    logic [2:0]        tx_data_select;
    logic              rc_ready;
    logic              rc_has_data;
    logic              drop_pulse;

    modport master (
        input  rx_has_data, rx_type, rx_dest, bad_decode, tx_ready, Packet_From_Node_Valid,
        output Packet_To_Node_Valid, Core_Load_Ack, buffer_select, tx_data_select,
               rc_ready, rc_has_data, drop_pulse
    );

    modport slave (
        output rx_has_data, rx_type, rx_dest, bad_decode, tx_ready, Packet_From_Node_Valid,
        input  Packet_To_Node_Valid, Core_Load_Ack, buffer_select, tx_data_select,
               rc_ready, rc_has_data, drop_pulse
    );
endinterface

// File: rtl/ring_ctrl_fsm.sv
// Token-ring node control FSM: token hold/pass, bounded retransmit, rx forward/deliver.
// Define ACK_TIMEOUT_EN to add the reply timeout counter (timeout acts as NACK).
module ring_ctrl_fsm #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned MASTER_ADDR = 0,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned MAX_BURST   = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              Clk_R,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] r_addr,
    ring_ctrl_fsm_if.master   bus
);
    localparam logic [2:0] PKT_TOKEN = 3'b111;
    localparam logic [2:0] PKT_ACK   = 3'b000;
    localparam logic [2:0] PKT_NACK  = 3'b011;

    localparam logic [2:0] SEL_ACK     = 3'd0;
    localparam logic [2:0] SEL_NACK    = 3'd1;
    localparam logic [2:0] SEL_FORWARD = 3'd2;
    localparam logic [2:0] SEL_TOKEN   = 3'd3;
    localparam logic [2:0] SEL_NEW     = 3'd4;

    localparam logic [3:0]        MAX_RETRY_C   = 4'(MAX_RETRY);
    localparam logic [3:0]        MAX_BURST_C   = 4'(MAX_BURST);
    localparam logic [ADDR_W-1:0] MASTER_ADDR_C = ADDR_W'(MASTER_ADDR);
    localparam logic [7:0]        TO_LAST       = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_INIT, S_CHECK_NODE, S_ENCODE, S_SEND_TX, S_LISTEN_TOK, S_SEND_TOKEN,
        S_LISTEN, S_CHECK_ADDR, S_FORWARD, S_SEND_NACK, S_SEND_NODE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic [3:0]        retry_q, retry_d;
    logic [2:0]        sel_q, sel_d;
    logic [2:0]        cap_type_q;
    logic [ADDR_W-1:0] cap_dest_q;
    logic              cap_bad_q;
    logic              timeout;
    logic              rx_ack, rx_nack;
    logic              o_to_node, o_load_ack, o_buf_sel, o_ready, o_strobe, o_drop;

    assign rx_ack  = bus.rx_has_data && (bus.rx_type == PKT_ACK);
    assign rx_nack = bus.rx_has_data && (bus.rx_type == PKT_NACK);

`ifdef ACK_TIMEOUT_EN
    logic [7:0] to_cnt_q, to_cnt_d;

    // Counts silent LISTEN_TOK cycles; fires on the ACK_TIMEOUT-th one.
    assign timeout = (state_q == S_LISTEN_TOK) && !bus.rx_has_data && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == S_SEND_TX) begin
            to_cnt_d = 8'd0;
        end else if (state_q == S_LISTEN_TOK) begin
            if (bus.rx_has_data)  to_cnt_d = 8'd0;
            else if (!timeout)    to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) to_cnt_q <= 8'd0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LAST;
    assign timeout            = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_INIT;
            burst_q <= 4'd0;
            retry_q <= 4'd0;
            sel_q   <= SEL_ACK;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            retry_q <= retry_d;
            sel_q   <= sel_d;
        end
    end

    // NOTE: the rx capture flops are reset too, so CHECK_ADDR never decodes X after reset.
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            cap_type_q <= 3'd0;
            cap_dest_q <= '0;
            cap_bad_q  <= 1'b0;
        end else if (state_q == S_LISTEN && bus.rx_has_data) begin
            cap_type_q <= bus.rx_type;
            cap_dest_q <= bus.rx_dest;
            cap_bad_q  <= bus.bad_decode;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        retry_d    = retry_q;
        sel_d      = sel_q;
        o_to_node  = 1'b0;
        o_load_ack = 1'b0;
        o_buf_sel  = 1'b0;
        o_ready    = 1'b0;
        o_strobe   = 1'b0;
        o_drop     = 1'b0;

        unique case (state_q)
            S_INIT: begin
                burst_d = 4'd0;
                retry_d = 4'd0;
                state_d = (r_addr == MASTER_ADDR_C) ? S_CHECK_NODE : S_LISTEN;
            end
            S_CHECK_NODE: begin
                o_buf_sel = 1'b1;
                if (bus.Packet_From_Node_Valid && (burst_q < MAX_BURST_C)) begin
                    state_d = S_ENCODE;
                    sel_d   = SEL_NEW;
                end else if (bus.tx_ready) begin
                    state_d = S_SEND_TOKEN;
                    sel_d   = SEL_TOKEN;
                end
            end
            S_ENCODE: begin
                o_strobe  = 1'b1;
                o_buf_sel = (retry_q == 4'd0);
                if (bus.tx_ready) state_d = S_SEND_TX;
            end
            S_SEND_TX: begin
                o_strobe   = 1'b1;
                o_load_ack = (retry_q == 4'd0);
                state_d    = S_LISTEN_TOK;
            end
            S_LISTEN_TOK: begin
                o_ready = 1'b1;
                if (rx_ack) begin
                    state_d = S_CHECK_NODE;
                    burst_d = burst_q + 4'd1;
                    retry_d = 4'd0;
                end else if (rx_nack || timeout) begin
                    if (retry_q < MAX_RETRY_C) begin
                        state_d = S_ENCODE;
                        retry_d = retry_q + 4'd1;
                    end else begin
                        o_drop  = 1'b1;
                        state_d = S_CHECK_NODE;
                        burst_d = burst_q + 4'd1;
                        retry_d = 4'd0;
                    end
                end
            end
            S_SEND_TOKEN: begin
                o_strobe = 1'b1;
                burst_d  = 4'd0;
                state_d  = S_LISTEN;
            end
            S_LISTEN: begin
                o_ready = 1'b1;
                if (bus.rx_has_data) state_d = S_CHECK_ADDR;
            end
            S_CHECK_ADDR: begin
                if (cap_type_q == PKT_TOKEN) begin
                    state_d = S_CHECK_NODE;
                end else if (cap_type_q == PKT_ACK || cap_type_q == PKT_NACK || cap_dest_q != r_addr) begin
                    state_d = S_FORWARD;
                    sel_d   = SEL_FORWARD;
                end else if (cap_bad_q) begin
                    state_d = S_SEND_NACK;
                    sel_d   = SEL_NACK;
                end else begin
                    state_d = S_SEND_NODE;
                    sel_d   = SEL_ACK;
                end
            end
            S_FORWARD, S_SEND_NACK: begin
                o_strobe = 1'b1;
                state_d  = S_LISTEN;
            end
            S_SEND_NODE: begin
                o_strobe  = 1'b1;
                o_to_node = 1'b1;
                state_d   = S_LISTEN;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign bus.Packet_To_Node_Valid = o_to_node;
    assign bus.Core_Load_Ack        = o_load_ack;
    assign bus.buffer_select        = o_buf_sel;
    assign bus.tx_data_select       = sel_q;
    assign bus.rc_ready             = o_ready;
    assign bus.rc_has_data          = o_strobe;
    assign bus.drop_pulse           = o_drop;
endmodule

// File: tb/tb_ring_ctrl_fsm.sv
// Self-checking bench for ring_ctrl_fsm: scoreboard of expected tx strobes plus per-scenario checks.
module tb_ring_ctrl_fsm;
    localparam int ADDR_W      = 4;
    localparam int MAX_RETRY   = 3;
    localparam int MAX_BURST   = 4;
    localparam int ACK_TIMEOUT = 8;

    localparam logic [2:0] PKT_TOKEN = 3'b111;
    localparam logic [2:0] PKT_ACK   = 3'b000;
    localparam logic [2:0] PKT_NACK  = 3'b011;
    localparam logic [2:0] PKT_DATAC = 3'b010;
    localparam logic [2:0] PKT_DATA3 = 3'b001;

    localparam logic [2:0] SEL_ACK     = 3'd0;
    localparam logic [2:0] SEL_NACK    = 3'd1;
    localparam logic [2:0] SEL_FORWARD = 3'd2;
    localparam logic [2:0] SEL_TOKEN   = 3'd3;
    localparam logic [2:0] SEL_NEW     = 3'd4;

    logic              Clk_R = 1'b0;
    logic              Rst_n = 1'b0;
    logic [ADDR_W-1:0] r_addr = '0;

    ring_ctrl_fsm_if #(.ADDR_W(ADDR_W)) bus ();

    ring_ctrl_fsm #(
        .ADDR_W(ADDR_W), .MASTER_ADDR(0), .MAX_RETRY(MAX_RETRY),
        .MAX_BURST(MAX_BURST), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .Clk_R (Clk_R),
        .Rst_n (Rst_n),
        .r_addr(r_addr),
        .bus   (bus)
    );

    always #5 Clk_R = ~Clk_R;

    typedef struct packed {
        logic [2:0] sel;
        logic       bsel;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   sends     = 0;
    int   load_acks = 0;
    int   drops     = 0;
    int   delivers  = 0;
    logic prev_tx   = 1'b0;

    // Each new tx strobe must match the oldest expected transmission.
    always @(negedge Clk_R) begin
        exp_t e;
        if (bus.rc_has_data && !prev_tx) begin
            sends++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_strobe: got sel=%0d bsel=%0b, nothing expected",
                         bus.tx_data_select, bus.buffer_select);
            end else begin
                e = sb.pop_front();
                if ({bus.tx_data_select, bus.buffer_select} !== {e.sel, e.bsel}) begin
                    errors++;
                    $display("FAIL sb_strobe: got sel=%0d bsel=%0b, want sel=%0d bsel=%0b",
                             bus.tx_data_select, bus.buffer_select, e.sel, e.bsel);
                end
            end
        end
        if (bus.Core_Load_Ack === 1'b1)        load_acks++;
        if (bus.drop_pulse === 1'b1)           drops++;
        if (bus.Packet_To_Node_Valid === 1'b1) delivers++;
        prev_tx = bus.rc_has_data;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] outs();
        return {bus.Packet_To_Node_Valid, bus.Core_Load_Ack, bus.buffer_select, bus.rc_ready,
                bus.rc_has_data, bus.drop_pulse, bus.tx_data_select};
    endfunction

    task automatic tick();
        @(posedge Clk_R);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rx_has_data            = 1'b0;
        bus.rx_type                = 3'd0;
        bus.rx_dest                = '0;
        bus.bad_decode             = 1'b0;
        bus.tx_ready               = 1'b0;
        bus.Packet_From_Node_Valid = 1'b0;
    endtask

    // Leaves the bench in the first cycle after release (state INIT).
    task automatic apply_reset(input logic [ADDR_W-1:0] addr, input logic rdy, input logic vld);
        Rst_n = 1'b0;
        idle_inputs();
        r_addr                     = addr;
        bus.tx_ready               = rdy;
        bus.Packet_From_Node_Valid = vld;
        repeat (2) tick();
        Rst_n = 1'b1;
    endtask

    task automatic send_rx(input logic [2:0] typ, input logic [ADDR_W-1:0] dest, input logic bad);
        bus.rx_has_data = 1'b1;
        bus.rx_type     = typ;
        bus.rx_dest     = dest;
        bus.bad_decode  = bad;
        tick();
        bus.rx_has_data = 1'b0;
        bus.bad_decode  = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        idle_inputs();
        bus.tx_ready               = 1'b1;
        bus.Packet_From_Node_Valid = 1'b1;
        repeat (2) tick();
        @(negedge Clk_R);
        checks++;
        if (outs() !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", outs(), 9'b0);
        end
    endtask

    task automatic test_token_pass();
        apply_reset(4'd0, 1'b1, 1'b0);
        @(negedge Clk_R);
        checks++;
        if (outs() !== 9'b0) begin
            errors++;
            $display("FAIL init_outputs: got %b want %b", outs(), 9'b0);
        end
        tick();
        @(negedge Clk_R);
        checks++;
        if ({bus.buffer_select, bus.rc_has_data, bus.rc_ready} !== 3'b100) begin
            errors++;
            $display("FAIL check_node_outputs: got %b want 100",
                     {bus.buffer_select, bus.rc_has_data, bus.rc_ready});
        end
        sb.push_back('{SEL_TOKEN, 1'b0});
        tick();
        @(negedge Clk_R);
        checks++;
        if ({bus.rc_has_data, bus.tx_data_select} !== {1'b1, SEL_TOKEN}) begin
            errors++;
            $display("FAIL token_cycle3: got strobe=%0b sel=%0d want strobe=1 sel=3",
                     bus.rc_has_data, bus.tx_data_select);
        end
        tick();
        @(negedge Clk_R);
        checks++;
        if ({bus.rc_ready, bus.rc_has_data} !== 2'b10) begin
            errors++;
            $display("FAIL token_to_listen: got %b want 10", {bus.rc_ready, bus.rc_has_data});
        end
    endtask

    task automatic test_rx_path();
        typedef struct packed {
            logic [2:0]        typ;
            logic [ADDR_W-1:0] dest;
            logic              bad;
            logic [2:0]        sel;
            logic              dlv;
        } rx_vec_t;
        rx_vec_t vecs [0:5];
        int      d0;
        vecs[0] = '{PKT_DATA3, 4'd5, 1'b0, SEL_ACK,     1'b1};
        vecs[1] = '{PKT_DATA3, 4'd5, 1'b1, SEL_NACK,    1'b0};
        vecs[2] = '{PKT_DATAC, 4'd3, 1'b0, SEL_FORWARD, 1'b0};
        vecs[3] = '{PKT_ACK,   4'd5, 1'b0, SEL_FORWARD, 1'b0};
        vecs[4] = '{PKT_NACK,  4'd5, 1'b1, SEL_FORWARD, 1'b0};
        vecs[5] = '{PKT_DATAC, 4'd9, 1'b1, SEL_FORWARD, 1'b0};
        apply_reset(4'd5, 1'b0, 1'b0);
        tick();
        d0 = delivers;
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{vecs[k].sel, 1'b0});
            send_rx(vecs[k].typ, vecs[k].dest, vecs[k].bad);
            tick();
            @(negedge Clk_R);
            checks++;
            if ({bus.rc_has_data, bus.tx_data_select, bus.Packet_To_Node_Valid} !==
                {1'b1, vecs[k].sel, vecs[k].dlv}) begin
                errors++;
                $display("FAIL rx_response_%0d: got strobe=%0b sel=%0d dlv=%0b want strobe=1 sel=%0d dlv=%0b",
                         k, bus.rc_has_data, bus.tx_data_select, bus.Packet_To_Node_Valid,
                         vecs[k].sel, vecs[k].dlv);
            end
            tick();
            @(negedge Clk_R);
            checks++;
            if ({bus.rc_ready, bus.rc_has_data, bus.Packet_To_Node_Valid} !== 3'b100) begin
                errors++;
                $display("FAIL rx_back_to_listen_%0d: got %b want 100", k,
                         {bus.rc_ready, bus.rc_has_data, bus.Packet_To_Node_Valid});
            end
        end
        send_rx(PKT_TOKEN, 4'd0, 1'b0);
        tick();
        @(negedge Clk_R);
        checks++;
        if ({bus.buffer_select, bus.rc_ready, bus.rc_has_data} !== 3'b100) begin
            errors++;
            $display("FAIL rx_token_to_check_node: got %b want 100",
                     {bus.buffer_select, bus.rc_ready, bus.rc_has_data});
        end
        tick();
        checks++;
        if (delivers - d0 !== 1) begin
            errors++;
            $display("FAIL rx_deliver_count: got %0d want 1", delivers - d0);
        end
    endtask

    task automatic test_nack(input int n_nack);
        int s0, l0, dr0, exp_sends, exp_drops;
        logic exp_drop;
        apply_reset(4'd0, 1'b1, 1'b1);
        s0  = sends;
        l0  = load_acks;
        dr0 = drops;
        sb.push_back('{SEL_NEW, 1'b1});
        tick();  // CHECK_NODE
        tick();  // ENCODE
        tick();  // SEND_TX
        @(negedge Clk_R);
        checks++;
        if ({bus.Core_Load_Ack, bus.buffer_select, bus.rc_has_data} !== 3'b101) begin
            errors++;
            $display("FAIL nack%0d_first_send: got %b want 101", n_nack,
                     {bus.Core_Load_Ack, bus.buffer_select, bus.rc_has_data});
        end
        tick();  // LISTEN_TOK
        bus.Packet_From_Node_Valid = 1'b0;
        for (int i = 1; i <= n_nack; i++) begin
            bus.rx_has_data = 1'b1;
            bus.rx_type     = PKT_NACK;
            if (i <= MAX_RETRY) sb.push_back('{SEL_NEW, 1'b0});
            else                bus.tx_ready = 1'b0;
            exp_drop = (i > MAX_RETRY);
            @(negedge Clk_R);
            checks++;
            if (bus.drop_pulse !== exp_drop) begin
                errors++;
                $display("FAIL nack%0d_drop_at_%0d: got %b want %b", n_nack, i, bus.drop_pulse, exp_drop);
            end
            tick();
            bus.rx_has_data = 1'b0;
            if (i <= MAX_RETRY) begin
                tick();  // SEND_TX
                tick();  // LISTEN_TOK
            end
        end
        if (n_nack <= MAX_RETRY) begin
            bus.tx_ready = 1'b0;
            send_rx(PKT_ACK, 4'd0, 1'b0);
        end
        @(negedge Clk_R);
        checks++;
        if ({bus.buffer_select, bus.rc_ready, bus.rc_has_data} !== 3'b100) begin
            errors++;
            $display("FAIL nack%0d_back_to_check_node: got %b want 100", n_nack,
                     {bus.buffer_select, bus.rc_ready, bus.rc_has_data});
        end
        tick();
        exp_sends = ((n_nack > MAX_RETRY) ? MAX_RETRY : n_nack) + 1;
        exp_drops = (n_nack > MAX_RETRY) ? 1 : 0;
        checks++;
        if (sends - s0 !== exp_sends) begin
            errors++;
            $display("FAIL nack%0d_send_count: got %0d want %0d", n_nack, sends - s0, exp_sends);
        end
        checks++;
        if (load_acks - l0 !== 1) begin
            errors++;
            $display("FAIL nack%0d_load_ack_count: got %0d want 1", n_nack, load_acks - l0);
        end
        checks++;
        if (drops - dr0 !== exp_drops) begin
            errors++;
            $display("FAIL nack%0d_drop_count: got %0d want %0d", n_nack, drops - dr0, exp_drops);
        end
    endtask

    task automatic test_burst();
        int s0, l0;
        apply_reset(4'd0, 1'b1, 1'b1);
        s0 = sends;
        l0 = load_acks;
        tick();  // CHECK_NODE
        for (int p = 0; p < MAX_BURST; p++) begin
            sb.push_back('{SEL_NEW, 1'b1});
            tick();  // ENCODE
            tick();  // SEND_TX
            tick();  // LISTEN_TOK
            send_rx(PKT_ACK, 4'd0, 1'b0);
        end
        sb.push_back('{SEL_TOKEN, 1'b0});
        tick();
        @(negedge Clk_R);
        checks++;
        if ({bus.rc_has_data, bus.tx_data_select, bus.buffer_select} !== {1'b1, SEL_TOKEN, 1'b0}) begin
            errors++;
            $display("FAIL burst_token_forced: got strobe=%0b sel=%0d bsel=%0b want strobe=1 sel=3 bsel=0",
                     bus.rc_has_data, bus.tx_data_select, bus.buffer_select);
        end
        tick();  // LISTEN
        checks++;
        if (load_acks - l0 !== MAX_BURST) begin
            errors++;
            $display("FAIL burst_load_acks: got %0d want %0d", load_acks - l0, MAX_BURST);
        end
        sb.push_back('{SEL_NEW, 1'b1});
        send_rx(PKT_TOKEN, 4'd0, 1'b0);
        tick();  // CHECK_NODE
        tick();  // ENCODE again: burst count restarted
        @(negedge Clk_R);
        checks++;
        if ({bus.rc_has_data, bus.tx_data_select, bus.buffer_select} !== {1'b1, SEL_NEW, 1'b1}) begin
            errors++;
            $display("FAIL burst_count_cleared: got strobe=%0b sel=%0d bsel=%0b want strobe=1 sel=4 bsel=1",
                     bus.rc_has_data, bus.tx_data_select, bus.buffer_select);
        end
        tick();
        checks++;
        if (sends - s0 !== MAX_BURST + 2) begin
            errors++;
            $display("FAIL burst_send_count: got %0d want %0d", sends - s0, MAX_BURST + 2);
        end
    endtask

    task automatic test_timeout_and_abort();
        int l0, dr0, s0;
        apply_reset(4'd0, 1'b1, 1'b1);
        l0  = load_acks;
        dr0 = drops;
        sb.push_back('{SEL_NEW, 1'b1});
        tick();  // CHECK_NODE
        tick();  // ENCODE
        tick();  // SEND_TX
        tick();  // LISTEN_TOK
        bus.Packet_From_Node_Valid = 1'b0;
        s0 = sends;
`ifdef ACK_TIMEOUT_EN
        begin
            int waited = 0;
            sb.push_back('{SEL_NEW, 1'b0});
            while (waited < 64) begin
                @(negedge Clk_R);
                if (bus.rc_has_data) break;
                waited++;
                tick();
            end
            checks++;
            if (waited !== ACK_TIMEOUT) begin
                errors++;
                $display("FAIL timeout_cycles: got %0d silent cycles want %0d", waited, ACK_TIMEOUT);
            end
            tick();  // SEND_TX
            tick();  // LISTEN_TOK
        end
`else
        repeat (3 * ACK_TIMEOUT) tick();
        checks++;
        if (sends !== s0) begin
            errors++;
            $display("FAIL no_timeout_strobe: got %0d extra sends want 0", sends - s0);
        end
        @(negedge Clk_R);
        checks++;
        if ({bus.rc_ready, bus.rc_has_data} !== 2'b10) begin
            errors++;
            $display("FAIL no_timeout_listening: got %b want 10", {bus.rc_ready, bus.rc_has_data});
        end
        tick();
`endif
        tick();
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 9'b0) begin
            errors++;
            $display("FAIL abort_outputs_immediate: got %b want %b", outs(), 9'b0);
        end
        repeat (3) tick();
        checks++;
        if (outs() !== 9'b0) begin
            errors++;
            $display("FAIL abort_outputs_held: got %b want %b", outs(), 9'b0);
        end
        checks++;
        if ({load_acks - l0, drops - dr0} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL abort_side_effects: got load_acks=%0d drops=%0d want 1 and 0",
                     load_acks - l0, drops - dr0);
        end
    endtask

    initial begin
        test_reset();
        test_token_pass();
        test_rx_path();
        test_nack(MAX_RETRY);
        test_nack(MAX_RETRY + 1);
        test_burst();
        test_timeout_and_abort();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drained: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
